pipe_stage_ctrl: RTL and testbench
==================================

Name: pipe_stage_ctrl

Overview:
- Central sequencer for the 5-stage MIPS pipeline (fetch/decode/execute/memory/writeback).
- Produces the per-stage enable word and the stall source, which the stage registers consume.
- Gates pipeline advance on the instruction-fetch and data-memory handshakes.
- Inserts a bubble on load-use hazards, squashes the wrong-path fetch after a taken branch or jump (one delay slot), and watches for memory hangs.

Parameters:
- MAX_WAIT, 255: max cycles one advance may wait on memory acks before the sticky timeout flag sets.
- CNT_W, 32: width of the performance counters (optional feature).

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- imem_req  out  1  fetch request, held until acked
- imem_ack  in  1  fetch data ready, single-cycle pulse
- mem_op  in  1  memory stage holds lw/sw
- dmem_req  out  1  data request, held until acked
- dmem_ack  in  1  data access done, single-cycle pulse
- ex_mem_to_reg  in  1  execute stage holds lw
- ex_rt  in  5  lw destination register
- id_rs  in  5  decode source register rs
- id_rt  in  5  decode source register rt
- id_valid  in  1  decode holds a real instruction
- redirect  in  1  taken beq or j resolved in execute
- fetch_enable  out  1  stage-register load enable
- decode_enable  out  1  stage-register load enable
- execute_enable  out  1  stage-register load enable
- memory_enable  out  1  stage-register load enable
- writeback_enable  out  1  stage-register load enable
- m_or_e  out  1  stall source: 0=E (load-use), 1=M (memory wait); valid while stalled
- bubble_ex  out  1  execute loads a NOP this advance
- flush_id  out  1  decode loads a NOP this advance
- timeout  out  1  sticky hang flag

Behaviour:
- State: i_done and d_done flags, each 1 bit; wait_cnt, 8 bits, saturating; timeout, sticky. Reset clears all of them.
- Reset values: all enables 0, imem_req=0, dmem_req=0, bubble_ex=0, flush_id=0, m_or_e=0, timeout=0.
- FSM has states RUN, WAIT.
- Reset enters RUN. RUN lasts exactly one cycle, then goes to WAIT.
- In WAIT, imem_req = ~i_done.
- In WAIT, dmem_req = mem_op & ~d_done.
- ack_i = i_done | imem_ack.
- ack_d = ~mem_op | d_done | dmem_ack.
- advance = WAIT & ack_i & ack_d. It is combinational, so an advance can happen in the same cycle as the last ack.
- If one ack arrives without advance, its done flag sets.
- On advance: every enable is 1 for exactly that cycle. Then i_done, d_done and wait_cnt clear.
- Load-use hazard: hz = ex_mem_to_reg & id_valid & ex_rt!=0 & (ex_rt==id_rs | ex_rt==id_rt).
- If hz on advance:
  - fetch_enable=0, decode_enable=0, bubble_ex=1.
  - i_done stays set, so no re-fetch.
  - Execute, memory and writeback still advance.
- If redirect on advance: flush_id=1. The delay-slot instruction already in decode proceeds; only the fetched wrong-path instruction is dropped.
- redirect & hz together: hz wins, flush_id=0. The branch cannot be in execute while the lw is.
- m_or_e while stalled: 1 if waiting on dmem, else 0 (fetch wait or load-use).
- Acks with no request outstanding are ignored.
- wait_cnt increments every WAIT cycle without advance. wait_cnt reaching MAX_WAIT sets timeout. Timeout is informational only: the pipeline keeps waiting.
- Reset mid-wait: outstanding requests drop the same cycle. Acks arriving later are ignored.

Optional Feature:
PIPE_CTRL_PERF_EN
- Defined:
  - Adds outputs perf_cycles, perf_advances, perf_lu_stalls and perf_mem_stalls, each CNT_W wide, wrapping.
  - perf_cycles counts every cycle after reset.
  - perf_advances counts advance cycles.
  - perf_lu_stalls counts advances with hz.
  - perf_mem_stalls counts WAIT cycles with dmem_req=1.
  - All four reset to 0.
- Undefined: no counters and no ports; all other behaviour identical.

Test Plan:
- Reset low, then release; imem_ack on the 2nd WAIT cycle, mem_op=0 -> imem_req=1 for 2 cycles; all enables=1 in exactly that cycle; timeout=0.
- mem_op=1; imem_ack at cycle 1; dmem_ack at cycle 4 -> imem_req drops after cycle 1; m_or_e=1 during cycles 2-3; advance at cycle 4.
- ex_mem_to_reg=1, ex_rt=5, id_rs=5, id_valid=1, imem_ack -> fetch_enable=0, decode_enable=0, bubble_ex=1 on advance; next advance needs no imem_ack.
- ex_rt=0 with id_rs=0 -> no bubble; normal advance.
- redirect=1 at advance -> flush_id=1, all enables=1; redirect with hz -> flush_id=0, bubble_ex=1.
- Withhold dmem_ack 300 cycles with MAX_WAIT=255 -> timeout=1 from wait cycle 255 and stays 1 after a later ack; with PIPE_CTRL_PERF_EN, perf_mem_stalls ≥ 255.

Source files
------------

// File: rtl/pipe_stage_ctrl.sv
// Pipeline sequencer for the 5-stage MIPS core: stage enables, load-use bubble, branch squash, memory hang watch.
// Optional performance counters are compiled in with `define PIPE_CTRL_PERF_EN.
module pipe_stage_ctrl #(
   parameter int unsigned MAX_WAIT = 255
`ifdef PIPE_CTRL_PERF_EN
  ,parameter int unsigned CNT_W    = 32
`endif
) (
   input  logic       clk,
   input  logic       resetn,
   output logic       imem_req,
   input  logic       imem_ack,
   input  logic       mem_op,
   output logic       dmem_req,
   input  logic       dmem_ack,
   input  logic       ex_mem_to_reg,
   input  logic [4:0] ex_rt,
   input  logic [4:0] id_rs,
   input  logic [4:0] id_rt,
   input  logic       id_valid,
   input  logic       redirect,
   output logic       fetch_enable,
   output logic       decode_enable,
   output logic       execute_enable,
   output logic       memory_enable,
   output logic       writeback_enable,
   output logic       m_or_e,
   output logic       bubble_ex,
   output logic       flush_id,
   output logic       timeout
`ifdef PIPE_CTRL_PERF_EN
  ,output logic [CNT_W-1:0] perf_cycles,
   output logic [CNT_W-1:0] perf_advances,
   output logic [CNT_W-1:0] perf_lu_stalls,
   output logic [CNT_W-1:0] perf_mem_stalls
`endif
);

   localparam int unsigned WAIT_W = 8;

   typedef enum logic {
      RUN  = 1'b0,
      WAIT = 1'b1
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic              i_done;
   logic              i_done_nxt;
   logic              d_done;
   logic              d_done_nxt;
   logic [WAIT_W-1:0] wait_cnt;
   logic [WAIT_W-1:0] wait_cnt_nxt;
   logic              timeout_nxt;
   logic              ack_i;
   logic              ack_d;
   logic              advance;
   logic              hz;

   // Load-use: the lw in execute writes a register the decode instruction reads ($0 never hazards)
   assign hz = ex_mem_to_reg & id_valid & (ex_rt != 5'd0) &
               ((ex_rt == id_rs) | (ex_rt == id_rt));

   // State and handshake bookkeeping
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state    <= RUN;
         i_done   <= 1'b0;
         d_done   <= 1'b0;
         wait_cnt <= '0;
         timeout  <= 1'b0;
      end else begin
         state    <= state_nxt;
         i_done   <= i_done_nxt;
         d_done   <= d_done_nxt;
         wait_cnt <= wait_cnt_nxt;
         timeout  <= timeout_nxt;
      end
   end

   // Next state, request handshakes and per-advance stage controls
   always_comb begin
      state_nxt        = state;
      i_done_nxt       = i_done;
      d_done_nxt       = d_done;
      wait_cnt_nxt     = wait_cnt;
      timeout_nxt      = timeout;
      imem_req         = 1'b0;
      dmem_req         = 1'b0;
      ack_i            = 1'b0;
      ack_d            = 1'b0;
      advance          = 1'b0;
      fetch_enable     = 1'b0;
      decode_enable    = 1'b0;
      execute_enable   = 1'b0;
      memory_enable    = 1'b0;
      writeback_enable = 1'b0;
      m_or_e           = 1'b0;
      bubble_ex        = 1'b0;
      flush_id         = 1'b0;

      case (state)
         RUN: begin
            state_nxt = WAIT;
         end
         WAIT: begin
            imem_req = ~i_done;
            dmem_req = mem_op & ~d_done;
            // Acks only count while their request is outstanding
            ack_i    = i_done | (imem_req & imem_ack);
            ack_d    = ~mem_op | d_done | (dmem_req & dmem_ack);
            advance  = ack_i & ack_d;
            if (advance) begin
               state_nxt        = RUN;
               fetch_enable     = ~hz;
               decode_enable    = ~hz;
               execute_enable   = 1'b1;
               memory_enable    = 1'b1;
               writeback_enable = 1'b1;
               bubble_ex        = hz;
               flush_id         = redirect & ~hz;
               // A held decode keeps its fetched instruction, so no re-fetch next time
               i_done_nxt       = hz;
               d_done_nxt       = 1'b0;
               wait_cnt_nxt     = '0;
            end else begin
               m_or_e     = ~ack_d;
               i_done_nxt = ack_i;
               d_done_nxt = d_done | (dmem_req & dmem_ack);
               if (wait_cnt != '1) begin
                  wait_cnt_nxt = wait_cnt + WAIT_W'(1);
               end
               if (32'(wait_cnt_nxt) >= MAX_WAIT) begin
                  timeout_nxt = 1'b1;
               end
            end
         end
         default: begin
            state_nxt = RUN;
         end
      endcase
   end

`ifdef PIPE_CTRL_PERF_EN
   // Wrapping event counters
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         perf_cycles     <= '0;
         perf_advances   <= '0;
         perf_lu_stalls  <= '0;
         perf_mem_stalls <= '0;
      end else begin
         perf_cycles <= perf_cycles + CNT_W'(1);
         if (advance) begin
            perf_advances <= perf_advances + CNT_W'(1);
         end
         if (advance & hz) begin
            perf_lu_stalls <= perf_lu_stalls + CNT_W'(1);
         end
         if (dmem_req) begin
            perf_mem_stalls <= perf_mem_stalls + CNT_W'(1);
         end
      end
   end
`endif

endmodule

// File: tb/tb_pipe_stage_ctrl.sv
// Scoreboard bench for pipe_stage_ctrl: a cycle model queues expected outputs, a negedge monitor compares.
module tb_pipe_stage_ctrl;

   localparam int unsigned MAX_WAIT = 255;

   logic       clk;
   logic       resetn;
   logic       imem_req, imem_ack, mem_op, dmem_req, dmem_ack;
   logic       ex_mem_to_reg, id_valid, redirect;
   logic [4:0] ex_rt, id_rs, id_rt;
   logic       fetch_enable, decode_enable, execute_enable, memory_enable, writeback_enable;
   logic       m_or_e, bubble_ex, flush_id, timeout;
`ifdef PIPE_CTRL_PERF_EN
   logic [31:0] perf_cycles, perf_advances, perf_lu_stalls, perf_mem_stalls;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   logic [10:0] sb_q[$];
   logic [10:0] sb_exp;
   logic [10:0] outs;

   int ireq_cycles, dreq_cycles, adv_cycles, bubble_cycles, flush_cycles;

   // Reference model state
   bit m_wait, m_idone, m_ddone, m_to;
   int m_cnt;

   pipe_stage_ctrl #(.MAX_WAIT(MAX_WAIT)) dut (
      .clk              (clk),
      .resetn           (resetn),
      .imem_req         (imem_req),
      .imem_ack         (imem_ack),
      .mem_op           (mem_op),
      .dmem_req         (dmem_req),
      .dmem_ack         (dmem_ack),
      .ex_mem_to_reg    (ex_mem_to_reg),
      .ex_rt            (ex_rt),
      .id_rs            (id_rs),
      .id_rt            (id_rt),
      .id_valid         (id_valid),
      .redirect         (redirect),
      .fetch_enable     (fetch_enable),
      .decode_enable    (decode_enable),
      .execute_enable   (execute_enable),
      .memory_enable    (memory_enable),
      .writeback_enable (writeback_enable),
      .m_or_e           (m_or_e),
      .bubble_ex        (bubble_ex),
      .flush_id         (flush_id),
      .timeout          (timeout)
`ifdef PIPE_CTRL_PERF_EN
     ,.perf_cycles      (perf_cycles),
      .perf_advances    (perf_advances),
      .perf_lu_stalls   (perf_lu_stalls),
      .perf_mem_stalls  (perf_mem_stalls)
`endif
   );

   assign outs = {imem_req, dmem_req, fetch_enable, decode_enable, execute_enable,
                  memory_enable, writeback_enable, m_or_e, bubble_ex, flush_id, timeout};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
      end
   endtask

   // Pop one expectation per cycle, mid-cycle
   always @(negedge clk) begin
      if (sb_q.size() != 0) begin
         sb_exp = sb_q.pop_front();
         check("cycle_outs", 32'(outs), 32'(sb_exp));
         if (imem_req)       ireq_cycles++;
         if (dmem_req)       dreq_cycles++;
         if (execute_enable) adv_cycles++;
         if (bubble_ex)      bubble_cycles++;
         if (flush_id)       flush_cycles++;
      end
   end

   task automatic clear_counts();
      ireq_cycles   = 0;
      dreq_cycles   = 0;
      adv_cycles    = 0;
      bubble_cycles = 0;
      flush_cycles  = 0;
   endtask

   task automatic model_reset();
      m_wait  = 1'b0;
      m_idone = 1'b0;
      m_ddone = 1'b0;
      m_to    = 1'b0;
      m_cnt   = 0;
   endtask

   // Queue this cycle's expected outputs, cross one clock edge, advance the model
   task automatic tick();
      logic ireq, dreq, igot, dgot, adv, lu;
      logic [10:0] e;
      ireq = m_wait && !m_idone;
      dreq = m_wait && mem_op && !m_ddone;
      igot = m_idone || (ireq && imem_ack);
      dgot = !mem_op || m_ddone || (dreq && dmem_ack);
      adv  = m_wait && igot && dgot;
      lu   = ex_mem_to_reg && id_valid && (ex_rt != 5'd0) && (ex_rt == id_rs || ex_rt == id_rt);
      e = {ireq, dreq, adv && !lu, adv && !lu, adv, adv, adv,
           dreq && !dmem_ack && !adv, adv && lu, adv && redirect && !lu, m_to};
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      if (adv) begin
         m_wait  = 1'b0;
         m_idone = lu;
         m_ddone = 1'b0;
         m_cnt   = 0;
      end else if (m_wait) begin
         if (ireq && imem_ack) m_idone = 1'b1;
         if (dreq && dmem_ack) m_ddone = 1'b1;
         if (m_cnt < 255) m_cnt++;
         if (m_cnt >= int'(MAX_WAIT)) m_to = 1'b1;
      end else begin
         m_wait = 1'b1;
      end
      imem_ack = 1'b0;
      dmem_ack = 1'b0;
   endtask

   initial begin
      resetn        = 1'b0;
      imem_ack      = 1'b0;
      dmem_ack      = 1'b0;
      mem_op        = 1'b0;
      ex_mem_to_reg = 1'b0;
      ex_rt         = 5'd0;
      id_rs         = 5'd0;
      id_rt         = 5'd0;
      id_valid      = 1'b0;
      redirect      = 1'b0;
      model_reset();
      clear_counts();

      // Reset state
      @(posedge clk);
      @(posedge clk);
      #1;
      check("reset_outs", 32'(outs), 32'd0);
      resetn = 1'b1;

      // Fetch-only advance: ack on the 2nd wait cycle
      clear_counts();
      tick();
      tick();
      imem_ack = 1'b1;
      tick();
      check("s1_imem_req_cycles", 32'(ireq_cycles), 32'd2);
      check("s1_advance_cycles", 32'(adv_cycles), 32'd1);
      check("s1_timeout", 32'(timeout), 32'd0);

      // Fetch ack first, data ack three cycles later
      clear_counts();
      mem_op = 1'b1;
      tick();
      imem_ack = 1'b1;
      tick();
      tick();
      tick();
      dmem_ack = 1'b1;
      tick();
      mem_op = 1'b0;
      check("s2_imem_req_cycles", 32'(ireq_cycles), 32'd1);
      check("s2_dmem_req_cycles", 32'(dreq_cycles), 32'd4);
      check("s2_advance_cycles", 32'(adv_cycles), 32'd1);

      // Load-use bubble; the following advance needs no fetch ack
      clear_counts();
      ex_mem_to_reg = 1'b1;
      ex_rt         = 5'd5;
      id_rs         = 5'd5;
      id_rt         = 5'd7;
      id_valid      = 1'b1;
      tick();
      imem_ack = 1'b1;
      tick();
      ex_mem_to_reg = 1'b0;
      tick();
      tick();
      check("s3_bubbles", 32'(bubble_cycles), 32'd1);
      check("s3_advances", 32'(adv_cycles), 32'd2);
      check("s3_imem_req_cycles", 32'(ireq_cycles), 32'd1);

      // $0 destination never hazards
      clear_counts();
      ex_mem_to_reg = 1'b1;
      ex_rt         = 5'd0;
      id_rs         = 5'd0;
      id_rt         = 5'd0;
      tick();
      imem_ack = 1'b1;
      tick();
      check("s4_bubbles", 32'(bubble_cycles), 32'd0);
      check("s4_advances", 32'(adv_cycles), 32'd1);

      // Redirect alone flushes; redirect with load-use bubbles instead
      clear_counts();
      ex_mem_to_reg = 1'b0;
      redirect      = 1'b1;
      tick();
      imem_ack = 1'b1;
      tick();
      ex_mem_to_reg = 1'b1;
      ex_rt         = 5'd3;
      id_rs         = 5'd1;
      id_rt         = 5'd3;
      tick();
      imem_ack = 1'b1;
      tick();
      redirect      = 1'b0;
      ex_mem_to_reg = 1'b0;
      tick();
      tick();
      check("s5_flushes", 32'(flush_cycles), 32'd1);
      check("s5_bubbles", 32'(bubble_cycles), 32'd1);

      // Random acks (including unrequested ones), hazards and redirects
      for (int i = 0; i < 300; i++) begin
         imem_ack      = ($urandom_range(2) == 0);
         dmem_ack      = ($urandom_range(2) == 0);
         if ($urandom_range(5) == 0) mem_op = 1'($urandom_range(1));
         ex_mem_to_reg = 1'($urandom_range(1));
         ex_rt         = 5'($urandom_range(3));
         id_rs         = 5'($urandom_range(3));
         id_rt         = 5'($urandom_range(3));
         id_valid      = 1'($urandom_range(1));
         redirect      = ($urandom_range(3) == 0);
         tick();
      end
      ex_mem_to_reg = 1'b0;
      redirect      = 1'b0;
      mem_op        = 1'b0;
      imem_ack      = 1'b1;
      tick();
      imem_ack      = 1'b1;
      tick();

      // Reset while both requests are outstanding; late acks ignored
      mem_op = 1'b1;
      while (m_wait) begin
         imem_ack = 1'b1;
         dmem_ack = 1'b1;
         tick();
      end
      tick();
      #2;
      resetn = 1'b0;
      #1;
      check("reset_mid_wait", 32'(outs), 32'd0);
      imem_ack = 1'b1;
      dmem_ack = 1'b1;
      @(posedge clk);
      #1;
      check("reset_held", 32'(outs), 32'd0);
      resetn = 1'b1;
      model_reset();
      imem_ack = 1'b1;
      dmem_ack = 1'b1;
      tick();
      tick();
      imem_ack = 1'b1;
      dmem_ack = 1'b1;
      tick();

      // Withheld data ack drives the sticky timeout
      tick();
      imem_ack = 1'b1;
      tick();
      repeat (253) tick();
      check("timeout_at_254", 32'(timeout), 32'd0);
      tick();
      check("timeout_at_255", 32'(timeout), 32'd1);
      repeat (45) tick();
      dmem_ack = 1'b1;
      tick();
      mem_op = 1'b0;
      tick();
      imem_ack = 1'b1;
      tick();
      check("timeout_sticky", 32'(timeout), 32'd1);
`ifdef PIPE_CTRL_PERF_EN
      check("perf_mem_stalls_min", 32'(perf_mem_stalls >= 32'd255), 32'd1);
`endif

      @(negedge clk);
      #1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
